// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard controller for a 5-stage pipeline.
// Tracks EX/MEM/WB producers, stalls on load-use, and registers the EX operand mux selects.
module fwd_hazard_unit #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              flush,
  output logic              stall_out,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic [CNT_W-1:0]  stall_count
);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              reg_write;
    logic              mem_read;
  } entry_t;

  localparam int NSTG = 3;
  localparam int EX   = 0;
  localparam int MEM  = 1;

  localparam logic [1:0] SEL_IDEX  = 2'd0;
  localparam logic [1:0] SEL_MEMWB = 2'd1;
  localparam logic [1:0] SEL_EXMEM = 2'd2;

  // Index 0 = EX, 1 = MEM, 2 = WB
  entry_t           stage_q [NSTG];
  entry_t           ex_in_d;
  logic             bubble_d;
  logic [1:0]       fwd_a_sel_q, fwd_a_sel_d;
  logic [1:0]       fwd_b_sel_q, fwd_b_sel_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;

  function automatic logic match(input entry_t e, input logic [REG_AW-1:0] rs, input logic used);
    return e.valid && e.reg_write && (e.rd == rs) && (rs != '0) && used;
  endfunction

  // Youngest producer wins; a load in EX cannot forward, it is handled by the stall instead.
  function automatic logic [1:0] next_sel(input entry_t ex_e, input entry_t mem_e,
                                          input logic [REG_AW-1:0] rs, input logic used);
    if (match(ex_e, rs, used) && !ex_e.mem_read) return SEL_EXMEM;
    else if (match(mem_e, rs, used))             return SEL_MEMWB;
    else                                         return SEL_IDEX;
  endfunction

  always_comb begin
    stall_out = id_valid && !flush && stage_q[EX].mem_read &&
                (match(stage_q[EX], id_rs1, id_rs1_used) ||
                 match(stage_q[EX], id_rs2, id_rs2_used));
    bubble_d  = stall_out || flush || !id_valid;

    ex_in_d = '0;
    if (!bubble_d) begin
      ex_in_d.valid     = 1'b1;
      ex_in_d.rd        = id_rd;
      ex_in_d.reg_write = id_reg_write;
      ex_in_d.mem_read  = id_mem_read;
    end

    fwd_a_sel_d = SEL_IDEX;
    fwd_b_sel_d = SEL_IDEX;
    if (!bubble_d) begin
      fwd_a_sel_d = next_sel(stage_q[EX], stage_q[MEM], id_rs1, id_rs1_used);
      fwd_b_sel_d = next_sel(stage_q[EX], stage_q[MEM], id_rs2, id_rs2_used);
    end

    stall_count_d = stall_count_q;
    if (stall_out && (stall_count_q != {CNT_W{1'b1}}))
      stall_count_d = stall_count_q + CNT_W'(1);
  end

  generate
    for (genvar gi = 0; gi < NSTG; gi++) begin : g_stage
      if (gi == 0) begin : g_ex
        always_ff @(posedge clk) begin
          if (rst) stage_q[gi] <= '0;
          else     stage_q[gi] <= ex_in_d;
        end
      end else begin : g_shift
        always_ff @(posedge clk) begin
          if (rst) stage_q[gi] <= '0;
          else     stage_q[gi] <= stage_q[gi-1];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_a_sel_q   <= SEL_IDEX;
      fwd_b_sel_q   <= SEL_IDEX;
      stall_count_q <= '0;
    end else begin
      fwd_a_sel_q   <= fwd_a_sel_d;
      fwd_b_sel_q   <= fwd_b_sel_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign fwd_a_sel   = fwd_a_sel_q;
  assign fwd_b_sel   = fwd_b_sel_q;
  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: hand-computed forwarding selects, stalls and counter.
// A narrow stall counter keeps the saturation check short.
module tb_fwd_hazard_unit;
  localparam int REG_AW = 5;
  localparam int CNT_W  = 4;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              id_valid;
  logic [REG_AW-1:0] id_rs1, id_rs2, id_rd;
  logic              id_rs1_used, id_rs2_used, id_reg_write, id_mem_read;
  logic              flush;
  logic              stall_out;
  logic [1:0]        fwd_a_sel, fwd_b_sel;
  logic [CNT_W-1:0]  stall_count;

  int total = 0;
  int bad   = 0;

  fwd_hazard_unit #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_rs1_used  (id_rs1_used),
    .id_rs2_used  (id_rs2_used),
    .id_rd        (id_rd),
    .id_reg_write (id_reg_write),
    .id_mem_read  (id_mem_read),
    .flush        (flush),
    .stall_out    (stall_out),
    .fwd_a_sel    (fwd_a_sel),
    .fwd_b_sel    (fwd_b_sel),
    .stall_count  (stall_count)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end else begin
      $display("ok   %s: got=%0d", tag, got);
    end
  endtask

  // Put one instruction in ID: valid, rs1, rs2, rs1_used, rs2_used, rd, reg_write, mem_read
  task automatic drive(input logic v, input int rs1, input int rs2, input logic u1, input logic u2,
                       input int rd, input logic rw, input logic mr);
    id_valid     = v;
    id_rs1       = REG_AW'(rs1);
    id_rs2       = REG_AW'(rs2);
    id_rs1_used  = u1;
    id_rs2_used  = u2;
    id_rd        = REG_AW'(rd);
    id_reg_write = rw;
    id_mem_read  = mr;
  endtask

  task automatic idle();
    drive(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    idle();
    repeat (2) tick();
    rst = 1'b0;

    // Reset state
    check_val("rst_sel_a", fwd_a_sel, 0);
    check_val("rst_sel_b", fwd_b_sel, 0);
    check_val("rst_cnt", stall_count, 0);
    #1 check_val("rst_stall", stall_out, 0);

    // 1: add x5,x1,x2 ; add x6,x5,x3
    drive(1, 1, 2, 1, 1, 5, 1, 0); #1 check_val("t1_prod_stall", stall_out, 0);
    tick();
    check_val("t1_prod_sel_a", fwd_a_sel, 0);
    drive(1, 5, 3, 1, 1, 6, 1, 0); #1 check_val("t1_cons_stall", stall_out, 0);
    tick();
    check_val("t1_cons_sel_a", fwd_a_sel, 2);
    check_val("t1_cons_sel_b", fwd_b_sel, 0);
    idle(); tick();
    check_val("t1_bubble_sel_a", fwd_a_sel, 0);

    // 2: add x5 ; nop ; sub x6,x3,x5
    drive(1, 1, 2, 1, 1, 5, 1, 0); tick();
    idle(); tick();
    drive(1, 3, 5, 1, 1, 6, 1, 0); #1 check_val("t2_sub_stall", stall_out, 0);
    tick();
    check_val("t2_sub_sel_a", fwd_a_sel, 0);
    check_val("t2_sub_sel_b", fwd_b_sel, 1);
    // add x5 ; add x5 ; or x7,x5,x5 -> youngest wins
    drive(1, 1, 2, 1, 1, 5, 1, 0); tick();
    drive(1, 1, 2, 1, 1, 5, 1, 0); tick();
    drive(1, 5, 5, 1, 1, 7, 1, 0); tick();
    check_val("t2_or_sel_a", fwd_a_sel, 2);
    check_val("t2_or_sel_b", fwd_b_sel, 2);
    idle(); tick(); tick();

    // 3: lw x7 ; add x8,x7,x7
    drive(1, 1, 0, 1, 0, 7, 1, 1); tick();
    drive(1, 7, 7, 1, 1, 8, 1, 0); #1 check_val("t3_stall_on", stall_out, 1);
    check_val("t3_cnt_pre", stall_count, 0);
    tick();
    check_val("t3_bubble_sel_a", fwd_a_sel, 0);
    check_val("t3_bubble_sel_b", fwd_b_sel, 0);
    check_val("t3_cnt", stall_count, 1);
    #1 check_val("t3_stall_off", stall_out, 0);
    tick();
    check_val("t3_cons_sel_a", fwd_a_sel, 1);
    check_val("t3_cons_sel_b", fwd_b_sel, 1);
    check_val("t3_cnt_hold", stall_count, 1);
    idle(); tick(); tick();

    // 4: x0 destination, reg_write=0, rs_used=0
    drive(1, 1, 2, 1, 1, 0, 1, 0); tick();
    drive(1, 0, 0, 1, 1, 3, 1, 0); tick();
    check_val("t4_x0_sel_a", fwd_a_sel, 0);
    check_val("t4_x0_sel_b", fwd_b_sel, 0);
    drive(1, 1, 0, 1, 0, 0, 1, 1); tick();
    drive(1, 0, 0, 1, 1, 3, 1, 0); #1 check_val("t4_lw_x0_stall", stall_out, 0);
    tick();
    drive(1, 1, 2, 1, 1, 9, 0, 0); tick();
    drive(1, 9, 9, 1, 1, 3, 1, 0); tick();
    check_val("t4_nowr_sel_a", fwd_a_sel, 0);
    check_val("t4_nowr_sel_b", fwd_b_sel, 0);
    drive(1, 1, 2, 1, 1, 10, 1, 0); tick();
    drive(1, 10, 10, 0, 1, 3, 1, 0); tick();
    check_val("t4_unused_sel_a", fwd_a_sel, 0);
    check_val("t4_used_sel_b", fwd_b_sel, 2);
    drive(1, 1, 0, 1, 0, 11, 1, 1); tick();
    drive(1, 11, 0, 0, 1, 3, 1, 0); #1 check_val("t4_unused_stall", stall_out, 0);
    idle(); tick(); tick();

    // 5: flush beats load-use
    drive(1, 1, 0, 1, 0, 12, 1, 1); tick();
    drive(1, 12, 0, 1, 0, 3, 1, 0); flush = 1'b1;
    #1 check_val("t5_flush_stall", stall_out, 0);
    tick();
    flush = 1'b0;
    check_val("t5_flush_sel_a", fwd_a_sel, 0);
    check_val("t5_flush_cnt", stall_count, 1);
    idle(); tick(); tick();
    // Saturation of the stall counter
    for (int i = 0; i < 20; i++) begin
      drive(1, 1, 0, 1, 0, 13, 1, 1); tick();
      drive(1, 13, 0, 1, 0, 14, 1, 0); #1 check_val($sformatf("t5_sat_stall_%0d", i), stall_out, 1);
      tick();
      check_val($sformatf("t5_sat_cnt_%0d", i), stall_count, (i + 2 > CMAX) ? CMAX : i + 2);
    end
    idle(); tick(); tick();

    // 6: mid-stream reset discards in-flight producers
    drive(1, 1, 2, 1, 1, 5, 1, 0); tick();
    drive(1, 5, 5, 1, 1, 6, 1, 0); rst = 1'b1;
    tick();
    rst = 1'b0;
    check_val("t6_rst_sel_a", fwd_a_sel, 0);
    check_val("t6_rst_sel_b", fwd_b_sel, 0);
    check_val("t6_rst_cnt", stall_count, 0);
    #1 check_val("t6_rst_stall", stall_out, 0);
    tick();
    check_val("t6_reader_sel_a", fwd_a_sel, 0);
    check_val("t6_reader_sel_b", fwd_b_sel, 0);
    drive(1, 1, 0, 1, 0, 7, 1, 1); tick();
    drive(1, 0, 0, 0, 0, 0, 0, 0); rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(1, 7, 7, 1, 1, 8, 1, 0); #1 check_val("t6_lw_rst_stall", stall_out, 0);
    tick();
    check_val("t6_lw_rst_sel_a", fwd_a_sel, 0);
    idle(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
